// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the dmem_port data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int f_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // BYTES / OFF_W / IDX_W for a given DATA_W and DEPTH
  function automatic int f_bytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int f_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int f_idx_w(input int depth);
    return f_clog2_min1(depth);
  endfunction

endpackage

// File: rtl/dmem_port_if.sv
// Request/response handshake bundle between the LSU (master) and dmem_port (slave).
interface dmem_port_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Byte-enabled single-port RAM model, one-cycle registered read; swap point for an SRAM macro.
module dmem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = 12
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic [IDX_W-1:0]    widx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [IDX_W-1:0]    ridx,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // read-before-write: rdata shows the word as it was before this edge's write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wmask[b]) begin
          r_mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata <= r_mem[ridx];
  end

endmodule

// File: rtl/dmem_port.sv
// Data memory behind the MEM stage: one outstanding request, LATENCY cycles accept-to-response,
// response held under resp_ready backpressure, new requests only after the response completes.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 64,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
  parameter int                LATENCY   = 1
) (
  input logic        clk,
  input logic        rst,
  dmem_port_if.slave bus
);

  localparam int BYTES = f_bytes(DATA_W);
  localparam int OFF_W = f_off_w(DATA_W);
  localparam int IDX_W = f_idx_w(DEPTH);
  localparam int CNT_W = f_clog2_min1(LATENCY + 1);

  state_t             r_state;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic               r_resp_err;
  logic               r_rd_ok;
  logic               r_we;
  logic               r_in_range;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;

  logic [ADDR_W-1:0]  w_off;
  logic [ADDR_W-1:0]  w_idx_full;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_ridx;
  logic               w_in_range;
  logic               w_accept;
  logic               w_arr_we;
  logic [DATA_W-1:0]  w_arr_rdata;
  logic [BYTES-1:0]   w_wmask;

  assign w_off      = bus.req_addr - BASE_ADDR;
  assign w_idx_full = w_off >> OFF_W;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_in_range = (bus.req_addr >= BASE_ADDR) && (w_idx_full < ADDR_W'(DEPTH));
  assign w_accept   = bus.req_valid && r_req_ready;
  assign w_wmask    = bus.req_wmask;

  // write commits on the accept edge; a reset on that same edge suppresses it
  assign w_arr_we   = w_accept && bus.req_we && w_in_range && !rst;
  assign w_ridx     = (r_state == IDLE) ? w_idx : r_idx;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk    (clk),
    .we     (w_arr_we),
    .wmask  (w_wmask),
    .widx   (w_idx),
    .wdata  (bus.req_wdata),
    .ridx   (w_ridx),
    .rdata  (w_arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rd_ok      <= 1'b0;
      r_we         <= 1'b0;
      r_in_range   <= 1'b0;
      r_idx        <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_idx       <= w_idx;
            r_in_range  <= w_in_range;
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= !w_in_range;
              r_rd_ok      <= !bus.req_we && w_in_range;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= !r_in_range;
            r_rd_ok      <= !r_we && r_in_range;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rd_ok      <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // array output only changes on an IDLE edge, so it is stable through WAIT/RESP
  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_rd_ok ? w_arr_rdata : '0;

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: three instances at LATENCY 1/3/4 sharing one stimulus driver.
module tb_dmem_port;

  localparam int          DW   = 64;
  localparam int          AW   = 64;
  localparam int          DEP  = 16;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_k      = 3'b111;
  logic [1:0]  sel        = 2'd0;
  logic        req_valid  = 1'b0;
  logic        req_we     = 1'b0;
  logic [63:0] req_addr   = '0;
  logic [63:0] req_wdata  = '0;
  logic [7:0]  req_wmask  = '0;
  logic        resp_ready = 1'b0;

  logic        o_rq_rdy [3];
  logic        o_rs_vld [3];
  logic [63:0] o_rs_dat [3];
  logic        o_rs_err [3];

  dmem_port_if #(.DATA_W(DW), .ADDR_W(AW)) bi [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bi[g].req_valid  = req_valid && (sel == 2'(g));
    assign bi[g].req_we     = req_we;
    assign bi[g].req_addr   = req_addr;
    assign bi[g].req_wdata  = req_wdata;
    assign bi[g].req_wmask  = req_wmask;
    assign bi[g].resp_ready = resp_ready;
    assign o_rq_rdy[g] = bi[g].req_ready;
    assign o_rs_vld[g] = bi[g].resp_valid;
    assign o_rs_dat[g] = bi[g].resp_rdata;
    assign o_rs_err[g] = bi[g].resp_err;

    dmem_port #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .DEPTH     (DEP),
      .BASE_ADDR (BASE),
      .LATENCY   ((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk (clk),
      .rst (rst_k[g]),
      .bus (bi[g])
    );
  end

  logic        m_rq_rdy;
  logic        m_rs_vld;
  logic [63:0] m_rs_dat;
  logic        m_rs_err;

  always_comb begin
    m_rq_rdy = o_rq_rdy[sel];
    m_rs_vld = o_rs_vld[sel];
    m_rs_dat = o_rs_dat[sel];
    m_rs_err = o_rs_err[sel];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
    end
  endtask

  task automatic do_req(input logic [1:0] s, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] mask,
                        output logic [63:0] rd, output logic err, output int lat);
    int k;
    sel = s; req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    req_valid = 1'b1;
    #1;
    k = 0;
    while (!m_rq_rdy && k < 20) begin
      tick();
      k++;
    end
    if (!m_rq_rdy) check("req_ready_timeout", 64'(m_rq_rdy), 64'd1);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!m_rs_vld && lat < 20) begin
      tick();
      lat++;
    end
    rd  = m_rs_dat;
    err = m_rs_err;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic [63:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [18];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] rd;
    logic        err;
    int          lat;
    int          seen;

    vecs[0]  = '{2'd0, 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0, 1};
    vecs[1]  = '{2'd0, 1'b0, 64'h8000_0008, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b0, 1};
    vecs[2]  = '{2'd0, 1'b1, 64'h8000_0008, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'h0, 1'b0, 1};
    vecs[3]  = '{2'd0, 1'b0, 64'h8000_000C, 64'h0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0, 1};
    vecs[4]  = '{2'd0, 1'b1, 64'h8000_0008, 64'hFF00_0000_0000_00EE, 8'h81, 64'h0, 1'b0, 1};
    vecs[5]  = '{2'd0, 1'b0, 64'h8000_0008, 64'h0, 8'h00, 64'hFF22_3344_AAAA_AAEE, 1'b0, 1};
    vecs[6]  = '{2'd0, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1, 1};
    vecs[7]  = '{2'd0, 1'b1, 64'h8000_0000, 64'h0000_0000_0000_0123, 8'hFF, 64'h0, 1'b0, 1};
    vecs[8]  = '{2'd0, 1'b1, 64'h8000_0078, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0, 1'b0, 1};
    vecs[9]  = '{2'd0, 1'b1, 64'h8000_0080, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b1, 1};
    vecs[10] = '{2'd0, 1'b0, 64'h8000_0078, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1};
    vecs[11] = '{2'd0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'h0000_0000_0000_0123, 1'b0, 1};
    vecs[12] = '{2'd0, 1'b1, 64'h8000_0078, 64'h0, 8'h00, 64'h0, 1'b0, 1};
    vecs[13] = '{2'd0, 1'b0, 64'h8000_0078, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1};
    vecs[14] = '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1, 1};
    vecs[15] = '{2'd1, 1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1'b0, 3};
    vecs[16] = '{2'd1, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0, 3};
    vecs[17] = '{2'd2, 1'b1, 64'h8000_0020, 64'h5555_AAAA_5555_AAAA, 8'hFF, 64'h0, 1'b0, 4};

    // reset state of every instance
    repeat (3) tick();
    rst_k = 3'b000;
    for (int g = 0; g < 3; g++) begin
      sel = 2'(g);
      #1;
      check("rst_req_ready", 64'(m_rq_rdy), 64'd1);
      check("rst_resp_valid", 64'(m_rs_vld), 64'd0);
      check("rst_resp_rdata", m_rs_dat, 64'd0);
      check("rst_resp_err", 64'(m_rs_err), 64'd0);
    end
    tick();

    for (int i = 0; i < 18; i++) begin
      do_req(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask, rd, err, lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_idle_ready", i), 64'(m_rq_rdy), 64'd1);
    end

    // LATENCY=3 read under 4 cycles of response backpressure
    sel = 2'd1; req_we = 1'b0; req_addr = 64'h8000_0010; req_wmask = 8'h00;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("bp_t1_valid", 64'(m_rs_vld), 64'd0);
    check("bp_t1_ready", 64'(m_rq_rdy), 64'd0);
    tick();
    check("bp_t2_valid", 64'(m_rs_vld), 64'd0);
    tick();
    check("bp_t3_valid", 64'(m_rs_vld), 64'd1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bp_hold%0d_valid", c), 64'(m_rs_vld), 64'd1);
      check($sformatf("bp_hold%0d_rdata", c), m_rs_dat, 64'h0123_4567_89AB_CDEF);
      check($sformatf("bp_hold%0d_err", c), 64'(m_rs_err), 64'd0);
      check($sformatf("bp_hold%0d_ready", c), 64'(m_rq_rdy), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_no_bypass", 64'(m_rq_rdy), 64'd0);
    tick();
    resp_ready = 1'b0;
    check("bp_done_valid", 64'(m_rs_vld), 64'd0);
    check("bp_done_ready", 64'(m_rq_rdy), 64'd1);

    // reset while a LATENCY=4 write sits in WAIT
    sel = 2'd2; req_we = 1'b1; req_addr = 64'h8000_0028;
    req_wdata = 64'h0F0F_0F0F_0F0F_0F0F; req_wmask = 8'hFF;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_k[2] = 1'b1;
    tick();
    rst_k[2] = 1'b0;
    check("midrst_valid", 64'(m_rs_vld), 64'd0);
    check("midrst_ready", 64'(m_rq_rdy), 64'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (m_rs_vld) seen++;
      tick();
    end
    check("midrst_no_resp", 64'(seen), 64'd0);
    do_req(2'd2, 1'b0, 64'h8000_0028, 64'h0, 8'h00, rd, err, lat);
    check("midrst_readback", rd, 64'h0F0F_0F0F_0F0F_0F0F);
    check("midrst_readback_lat", 64'(lat), 64'd4);
    do_req(2'd2, 1'b0, 64'h8000_0020, 64'h0, 8'h00, rd, err, lat);
    check("midrst_prior_write", rd, 64'h5555_AAAA_5555_AAAA);

    // reset on the same edge as an accept: the write must not land
    do_req(2'd0, 1'b1, 64'h8000_0030, 64'h0000_0000_0000_1111, 8'hFF, rd, err, lat);
    sel = 2'd0; req_we = 1'b1; req_addr = 64'h8000_0030;
    req_wdata = 64'h0000_0000_0000_2222; req_wmask = 8'hFF;
    req_valid = 1'b1;
    rst_k[0] = 1'b1;
    tick();
    req_valid = 1'b0;
    rst_k[0] = 1'b0;
    check("rstacc_valid", 64'(m_rs_vld), 64'd0);
    tick();
    check("rstacc_valid2", 64'(m_rs_vld), 64'd0);
    do_req(2'd0, 1'b0, 64'h8000_0030, 64'h0, 8'h00, rd, err, lat);
    check("rstacc_readback", rd, 64'h0000_0000_0000_1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Synthesizable, parametrised data memory with a valid/ready request/response handshake, sitting behind the MEM stage (LSU side).
- Replaces the combinational DPI pmem read / clocked write model.
- Adds configurable access latency, backpressure, byte-masked writes and out-of-range error reporting, all at a configurable data width and depth.
- One outstanding transaction at a time.

Parameters:
- DATA_W, 64, data bus width in bits; must be a power of 2, at least 8.
- ADDR_W, 64, byte address width.
- DEPTH, 4096, number of DATA_W-bit words.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- LATENCY, 1, cycles from request accept to resp_valid; must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wmask  in  DATA_W/8  byte write enables; bit i controls wdata[8i+7:8i]
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_W  read data; 0 for writes and errors
- resp_err  out  1  address out of range

Behaviour:
- Clock and reset: single clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1 (first cycle after rst deasserts), resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Memory array contents are not reset.
- Handshakes: a request is accepted when req_valid & req_ready; the response completes when resp_valid & resp_ready.
- Address decode:
  - off = req_addr - BASE_ADDR, computed at ADDR_W, unsigned.
  - idx = off >> log2(DATA_W/8); low offset bits are ignored, so accesses are word-aligned.
  - in_range = (req_addr >= BASE_ADDR) && (idx < DEPTH).
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On accept, capture we, idx, in_range. If LATENCY==1 go to RESP; otherwise go to WAIT with cnt=LATENCY-1.
  - WAIT: req_ready=0. cnt decrements each cycle; when cnt reaches 1, go to RESP on the next edge. Total accept-to-resp_valid delay is exactly LATENCY cycles.
  - RESP: resp_valid=1, req_ready=0. resp_rdata and resp_err are held stable while resp_ready=0. On resp_ready go to IDLE; req_ready rises the following cycle, so there is no same-cycle resp/accept bypass.
- Writes:
  - Committed to the array at the accept edge, only for bytes with wmask=1 and only if in_range.
  - Still produce a response: rdata=0, err=!in_range.
  - wmask=0 is a legal no-op write and still responds.
- Reads:
  - Array is read at the captured idx.
  - resp_rdata is registered and equals the array contents as of the accept edge. A write accepted earlier is visible to a later read.
  - Out of range: rdata=0, err=1, array untouched.
- Inputs while busy: req_* are ignored in WAIT and RESP; the requester must hold them until req_ready.
- Reset mid-operation: rst in WAIT or RESP drops the transaction; resp_valid falls at the next edge with no response delivered. A write already committed at accept remains in memory.
- rst asserted on the same edge as an accept: reset wins, no write commits.

Decomposition:
- Shared package dmem_pkg: FSM state enum (IDLE/WAIT/RESP), BYTES=DATA_W/8, OFF_W=$clog2(BYTES), IDX_W=$clog2(DEPTH).
- One sub-module, dmem_array:
  - Ports: clk, we, wmask, widx, wdata, ridx, registered rdata.
  - Plain byte-enabled single-port RAM model so it can later be swapped for an SRAM macro.
- FSM, counter, decode and error logic stay in dmem_port.

Test Plan:
- Reset/idle: hold rst 3 cycles, release → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Write then read, LATENCY=1:
  - write 0x8000_0008, wdata 0x1122334455667788, wmask 0xFF → resp_valid one cycle after accept, err=0, rdata=0.
  - read 0x8000_0008 → rdata=0x1122334455667788 one cycle after accept.
- Byte mask: write 0xAAAAAAAAAAAAAAAA mask 0x0F over the previous word → read returns 0x11223344AAAAAAAA.
- Latency and backpressure:
  - LATENCY=3: read accepted at t → resp_valid at t+3.
  - resp_ready held 0 for 4 cycles → rdata and err stable, req_ready=0 throughout.
  - resp_ready=1 → req_ready=1 the next cycle.
- Range errors:
  - read 0x7FFF_FFF8 → err=1, rdata=0.
  - write BASE_ADDR + DEPTH*8 → err=1.
  - read back word DEPTH-1 → unchanged.
- Reset mid-op: LATENCY=4, assert rst in WAIT → no resp_valid, req_ready=1 after release; prior committed write still readable.
